// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative write-back / write-allocate L2 with
// tree-PLRU replacement and a one-entry victim write buffer. Fills are issued
// ahead of dirty writebacks; the buffer drains when no request is pending.
module l2_cache_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int ADDR_W = 16,
  parameter int UP_W   = 128,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [UP_W-1:0]   mem_wdata,
  output logic [UP_W-1:0]   mem_rdata,
  output logic              mem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int OFF_W  = $clog2(LINE_W/8);
  localparam int UP_OFF = $clog2(UP_W/8);
  localparam int NBLK   = LINE_W/UP_W;
  localparam int BLK_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LOG_W  = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESP, DRAIN} state_t;

  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } evict_t;

  state_t state, state_nxt;

  // storage: data/tag arrays are never cleared, valid/dirty/PLRU are
  logic [LINE_W-1:0]            data_q [SETS][WAYS];
  logic [TAG_W-1:0]             tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]    valid_q;
  logic [SETS-1:0][WAYS-1:0]    dirty_q;
  logic [SETS-1:0][WAYS-2:0]    plru_q;

  evict_t                       ev;
  logic [LOG_W-1:0]             way_q;
  logic [1:0]                   starve_q;

  // address decode
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [BLK_W-1:0]  blk;
  logic [ADDR_W-1:0] line_addr;

  assign idx       = mem_address[OFF_W +: IDX_W];
  assign tag       = mem_address[ADDR_W-1 -: TAG_W];
  assign blk       = BLK_W'(mem_address[OFF_W-1:0] >> UP_OFF);
  assign line_addr = {tag, idx, OFF_W'(0)};

  // per-way tag compare, all ways in parallel
  logic [WAYS-1:0] way_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_hit[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
  end

  logic             any_hit, inv_found;
  logic [LOG_W-1:0] hit_way, inv_way, plru_way, vic_way, node;
  logic             nb;

  assign any_hit = |way_hit;

  // hit way, lowest invalid way, and PLRU walk from the root
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (way_hit[i]) hit_way = LOG_W'(i);
      if (!valid_q[idx][i]) begin
        inv_found = 1'b1;
        inv_way   = LOG_W'(i);
      end
    end
    plru_way = '0;
    node     = LOG_W'(1);
    nb       = 1'b0;
    for (int l = 0; l < LOG_W; l++) begin
      nb                   = plru_q[idx][node - LOG_W'(1)];
      plru_way[LOG_W-1-l]  = nb;
      node                 = (node << 1) | LOG_W'(nb);
    end
    vic_way = inv_found ? inv_way : plru_way;
  end

  logic [WAYS-2:0]  plru_upd;
  logic [LOG_W-1:0] unode;
  logic             ub;

  // PLRU update: every node on the accessed path points away from it
  always_comb begin
    plru_upd = plru_q[idx];
    unode    = LOG_W'(1);
    ub       = 1'b0;
    for (int l = 0; l < LOG_W; l++) begin
      ub                            = way_q[LOG_W-1-l];
      plru_upd[unode - LOG_W'(1)]   = ~ub;
      unode                         = (unode << 1) | LOG_W'(ub);
    end
  end

  logic vic_valid, vic_dirty, ev_match, blocked;
  assign vic_valid = valid_q[idx][vic_way];
  assign vic_dirty = dirty_q[idx][vic_way];
  // a miss on the line sitting in the buffer must wait for it to reach memory
  assign ev_match  = ev.full && (ev.addr == line_addr);
  // after several back-to-back responses with a full buffer, let the drain win once
  assign blocked   = ev.full && (starve_q == 2'd3);

  logic [LINE_W-1:0] cur_line;
  assign cur_line = data_q[idx][way_q];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and outputs
  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if ((mem_read || mem_write) && !blocked) state_nxt = LOOKUP;
        else if (ev.full)                        state_nxt = DRAIN;
      end
      LOOKUP: begin
        if (any_hit)                                state_nxt = RESP;
        else if (ev_match)                          state_nxt = DRAIN;
        else if (ev.full && vic_valid && vic_dirty) state_nxt = DRAIN;
        else                                        state_nxt = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr;
        if (pmem_resp) state_nxt = RESP;
      end
      RESP: begin
        mem_resp = 1'b1;
        if (mem_read) mem_rdata = cur_line[blk*UP_W +: UP_W];
        state_nxt = IDLE;
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = ev.addr;
        pmem_wdata   = ev.data;
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control state: way select, valid/dirty/PLRU, victim buffer, drain fairness
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      way_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
      ev       <= '0;
      starve_q <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          way_q <= any_hit ? hit_way : vic_way;
          if (state_nxt == FILL && vic_valid && vic_dirty) begin
            ev.full <= 1'b1;
            ev.addr <= {tag_q[idx][vic_way], idx, OFF_W'(0)};
            ev.data <= data_q[idx][vic_way];
          end
        end
        FILL: if (pmem_resp) begin
          valid_q[idx][way_q] <= 1'b1;
          dirty_q[idx][way_q] <= 1'b0;
        end
        RESP: begin
          plru_q[idx] <= plru_upd;
          if (mem_write) dirty_q[idx][way_q] <= 1'b1;
          if (!ev.full)                starve_q <= 2'd0;
          else if (starve_q != 2'd3)   starve_q <= starve_q + 2'd1;
        end
        DRAIN: if (pmem_resp) begin
          ev.full  <= 1'b0;
          starve_q <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  // data and tag arrays: line fill, then block merge on upstream write
  always_ff @(posedge clk) begin
    if (state == FILL && pmem_resp) begin
      data_q[idx][way_q] <= pmem_rdata;
      tag_q[idx][way_q]  <= tag;
    end else if (state == RESP && mem_write) begin
      data_q[idx][way_q][blk*UP_W +: UP_W] <= mem_wdata;
    end
  end

endmodule
